instr_fetch_sequencer: RTL and testbench

INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

---
 rtl/instr_fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: PC generation, one-entry fetch buffer toward decode, redirect and stall handling.
// Optional fetch address range check with HALT on violation is enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Ready,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] ImemAddress,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        Valid,
  output logic [15:0] FetchCount,
  output logic        Fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_e;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;
`endif

  localparam logic [31:0] RST_PC     = {RESET_PC[31:2], 2'b00};
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        halted;
  logic        out_of_range;
  logic        slot_free;
  logic        unused_ok;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign halted       = (state_q == HALT);
  assign out_of_range = ({1'b0, pc_q} >= IMEM_BYTES);
`else
  assign halted       = 1'b0;
  assign out_of_range = 1'b0;
`endif

  assign slot_free = !valid_q || Ready;
  assign unused_ok = ^{BranchTarget[1:0], IMEM_BYTES, out_of_range};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Priority: HALT (reset-only exit) > redirect > stall > normal fetch/hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (halted) begin
      state_d = state_q;
    end else if (BranchTaken) begin
      pc_d    = {BranchTarget[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (!Stall) begin
      if (valid_q && Ready) cnt_d = cnt_q + 16'd1;
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH, HOLD: begin
          if (slot_free) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (out_of_range) begin
              fault_d = 1'b1;
              valid_d = 1'b0;
              state_d = HALT;
            end else begin
              instr_d = ImemInstruction;
              pcp4_d  = pc_q + 32'd4;
              pc_d    = pc_q + 32'd4;
              valid_d = 1'b1;
              state_d = FETCH;
            end
`else
            instr_d = ImemInstruction;
            pcp4_d  = pc_q + 32'd4;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
            state_d = FETCH;
`endif
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign ImemAddress = pc_q;
  assign Instruction = instr_q;
  assign PCPlus4     = pcp4_q;
  assign Valid       = valid_q;
  assign FetchCount  = cnt_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign Fault       = fault_q;
`else
  assign Fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: vector table through a scoreboard queue, plus hand-written redirect/range sequences.
module tb_instr_fetch_sequencer;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] p4;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic        flt;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    exp_t        e;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        Ready = 1'b0;
  logic [31:0] ImemInstruction;
  logic [31:0] ImemAddress;
  logic [31:0] Instruction;
  logic [31:0] PCPlus4;
  logic        Valid;
  logic [15:0] FetchCount;
  logic        Fault;

  logic [31:0] mem [128];
  exp_t        sb [$];
  vec_t        tbl [15];
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;
  always_comb ImemInstruction = mem[ImemAddress[8:2]];

  instr_fetch_sequencer #(.RESET_PC(32'h0), .IMEM_WORDS(128)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Ready(Ready), .ImemInstruction(ImemInstruction),
    .ImemAddress(ImemAddress), .Instruction(Instruction), .PCPlus4(PCPlus4),
    .Valid(Valid), .FetchCount(FetchCount), .Fault(Fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'd0, Valid}, {31'd0, e.v});
    chk({tag, ".instr"}, Instruction, e.ins);
    chk({tag, ".pcp4"},  PCPlus4, e.p4);
    chk({tag, ".addr"},  ImemAddress, e.pc);
    chk({tag, ".count"}, {16'd0, FetchCount}, {16'd0, e.cnt});
    chk({tag, ".fault"}, {31'd0, Fault}, {31'd0, e.flt});
  endtask

  function automatic vec_t mk(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt,
                              input logic v, input logic [31:0] ins, input logic [31:0] p4,
                              input logic [31:0] pc, input logic [15:0] cnt);
    vec_t t;
    t.rdy = rdy; t.stl = stl; t.br = br; t.tgt = tgt;
    t.e.v = v; t.e.ins = ins; t.e.p4 = p4; t.e.pc = pc; t.e.cnt = cnt; t.e.flt = 1'b0;
    return t;
  endfunction

  function automatic exp_t mke(input logic v, input logic [31:0] ins, input logic [31:0] p4,
                               input logic [31:0] pc, input logic [15:0] cnt, input logic flt);
    exp_t e;
    e.v = v; e.ins = ins; e.p4 = p4; e.pc = pc; e.cnt = cnt; e.flt = flt;
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expectation, and compare after the edge.
  task automatic step(input string tag, input logic rdy, input logic stl, input logic br,
                      input logic [31:0] tgt, input exp_t e);
    exp_t got;
    Ready = rdy; Stall = stl; BranchTaken = br; BranchTarget = tgt;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      got = sb.pop_front();
      chk_all(tag, got);
    end
  endtask

  task automatic reset_and_release();
    Ready = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 3;

    tbl[0]  = mk(1, 0, 0, 32'h0,  0, 32'd0,  32'd0,   32'd0,   16'd0);
    tbl[1]  = mk(1, 0, 0, 32'h0,  1, 32'd0,  32'd4,   32'd4,   16'd0);
    tbl[2]  = mk(1, 0, 0, 32'h0,  1, 32'd3,  32'd8,   32'd8,   16'd1);
    tbl[3]  = mk(1, 0, 0, 32'h0,  1, 32'd6,  32'd12,  32'd12,  16'd2);
    tbl[4]  = mk(1, 0, 0, 32'h0,  1, 32'd9,  32'd16,  32'd16,  16'd3);
    tbl[5]  = mk(0, 0, 0, 32'h0,  1, 32'd9,  32'd16,  32'd16,  16'd3);
    tbl[6]  = mk(0, 0, 0, 32'h0,  1, 32'd9,  32'd16,  32'd16,  16'd3);
    tbl[7]  = mk(0, 0, 0, 32'h0,  1, 32'd9,  32'd16,  32'd16,  16'd3);
    tbl[8]  = mk(1, 0, 0, 32'h0,  1, 32'd12, 32'd20,  32'd20,  16'd4);
    tbl[9]  = mk(1, 1, 0, 32'h0,  1, 32'd12, 32'd20,  32'd20,  16'd4);
    tbl[10] = mk(1, 1, 0, 32'h0,  1, 32'd12, 32'd20,  32'd20,  16'd4);
    tbl[11] = mk(0, 0, 0, 32'h0,  1, 32'd12, 32'd20,  32'd20,  16'd4);
    tbl[12] = mk(0, 1, 1, 32'h43, 0, 32'd12, 32'd20,  32'h40,  16'd4);
    tbl[13] = mk(0, 0, 0, 32'h0,  1, 32'd48, 32'h44,  32'h44,  16'd4);
    tbl[14] = mk(0, 0, 0, 32'h0,  1, 32'd48, 32'h44,  32'h44,  16'd4);

    // Reset held: outputs at their reset values.
    repeat (2) @(posedge Clk);
    #1;
    chk_all("reset", mke(0, 32'd0, 32'd0, 32'd0, 16'd0, 0));
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < 15; i++)
      step($sformatf("row%0d", i), tbl[i].rdy, tbl[i].stl, tbl[i].br, tbl[i].tgt, tbl[i].e);

    // Asynchronous reset while in HOLD, checked before the next clock edge.
    #2;
    Rst = 1'b0;
    #1;
    chk_all("async_rst", mke(0, 32'd0, 32'd0, 32'd0, 16'd0, 0));
    @(negedge Clk);
    Rst = 1'b1;

    reset_and_release();
    step("h_idle", 1, 0, 0, 32'h0, mke(0, 32'd0, 32'd0, 32'd0, 16'd0, 0));
`ifdef FETCH_BOUNDS_CHECK_EN
    step("b_br",    1, 0, 1, 32'h1FC, mke(0, 32'd0,   32'd0,    32'h1FC, 16'd0, 0));
    step("b_last",  1, 0, 0, 32'h0,   mke(1, 32'd381, 32'h200,  32'h200, 16'd0, 0));
    step("b_fault", 1, 0, 0, 32'h0,   mke(0, 32'd381, 32'h200,  32'h200, 16'd1, 1));
    step("b_ignbr", 1, 0, 1, 32'h8,   mke(0, 32'd381, 32'h200,  32'h200, 16'd1, 1));
    #2;
    Rst = 1'b0;
    #1;
    chk_all("b_rst", mke(0, 32'd0, 32'd0, 32'd0, 16'd0, 0));
    @(negedge Clk);
    Rst = 1'b1;
`else
    step("w_br",    1, 0, 1, 32'hFFFF_FFFF, mke(0, 32'd0,   32'd0, 32'hFFFF_FFFC, 16'd0, 0));
    step("w_last",  1, 0, 0, 32'h0,         mke(1, 32'd381, 32'd0, 32'd0,         16'd0, 0));
    step("w_wrap",  1, 0, 0, 32'h0,         mke(1, 32'd0,   32'd4, 32'd4,         16'd1, 0));
    step("w_brrdy", 1, 0, 1, 32'h10,        mke(0, 32'd0,   32'd4, 32'h10,        16'd1, 0));
    step("w_tgt",   0, 0, 0, 32'h0,         mke(1, 32'd12,  32'h14, 32'h14,       16'd1, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
